// File: rtl/softmax_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : softmax_rd_arbiter                                               |
// | Brief   : Round-robin, burst-bounded read arbiter sharing one async-read   |
// |           vector memory among the three softmax read streams.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module softmax_rd_arbiter #(
  parameter int DWIDTH = 128,
  parameter int AWIDTH = 8,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2:0]        req,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [AWIDTH-1:0] addr2,
  output logic [2:0]        gnt,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_q,
  output logic [DWIDTH-1:0] rdata,
  output logic [2:0]        rvalid,
  output logic              busy
);

  localparam logic [3:0] C_BURST = 4'(BURST);

  typedef enum logic [1:0] {
    OWN_R0   = 2'd0,
    OWN_R1   = 2'd1,
    OWN_R2   = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  owner_t            owner_q, owner_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic              busy_q, busy_d;

  logic [2:0] own_onehot;
  logic       own_req;
  logic       lock;
  logic [2:0] rr_gnt;
  logic [2:0] gnt_w;
  owner_t     gnt_own;

  always_comb begin
    own_onehot = 3'b000;
    case (owner_q)
      OWN_R0:  own_onehot = 3'b001;
      OWN_R1:  own_onehot = 3'b010;
      OWN_R2:  own_onehot = 3'b100;
      default: own_onehot = 3'b000;
    endcase
  end

  assign own_req = |(own_onehot & req);
  assign lock    = own_req && (cnt_q < C_BURST);

  // Rotating priority scan starting at ptr_q.
  always_comb begin
    rr_gnt = 3'b000;
    case (ptr_q)
      2'd1: begin
        if (req[1])      rr_gnt = 3'b010;
        else if (req[2]) rr_gnt = 3'b100;
        else if (req[0]) rr_gnt = 3'b001;
      end
      2'd2: begin
        if (req[2])      rr_gnt = 3'b100;
        else if (req[0]) rr_gnt = 3'b001;
        else if (req[1]) rr_gnt = 3'b010;
      end
      default: begin
        if (req[0])      rr_gnt = 3'b001;
        else if (req[1]) rr_gnt = 3'b010;
        else if (req[2]) rr_gnt = 3'b100;
      end
    endcase
  end

  assign gnt_w = lock ? own_onehot : rr_gnt;

  always_comb begin
    gnt_own  = OWN_R0;
    mem_addr = '0;
    case (gnt_w)
      3'b001: begin gnt_own = OWN_R0; mem_addr = addr0; end
      3'b010: begin gnt_own = OWN_R1; mem_addr = addr1; end
      3'b100: begin gnt_own = OWN_R2; mem_addr = addr2; end
      default: begin gnt_own = OWN_R0; mem_addr = '0; end
    endcase
  end

  always_comb begin
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    rdata_d  = rdata_q;
    rvalid_d = gnt_w;
    busy_d   = 1'b0;
    if (|gnt_w) begin
      rdata_d = mem_q;
      if (gnt_own == owner_q && cnt_q < C_BURST) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
        // New owner, or an exhausted owner re-winning through round-robin.
        owner_d = gnt_own;
        cnt_d   = 4'd1;
        case (gnt_own)
          OWN_R0:  ptr_d = 2'd1;
          OWN_R1:  ptr_d = 2'd2;
          default: ptr_d = 2'd0;
        endcase
      end
      busy_d = (cnt_d < C_BURST);
    end else if (owner_q != OWN_NONE && !own_req) begin
      owner_d = OWN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || init) begin
      owner_q  <= OWN_NONE;
      cnt_q    <= 4'd0;
      ptr_q    <= 2'd0;
      rdata_q  <= '0;
      rvalid_q <= 3'b000;
      busy_q   <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_w;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_softmax_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_softmax_rd_arbiter                                            |
// | Brief   : Scoreboard bench for softmax_rd_arbiter (BURST=4 and BURST=1).   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_softmax_rd_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, init;
  logic [2:0]   req;
  logic [7:0]   addr0, addr1, addr2;
  logic [2:0]   gnt4, gnt1, rvalid4, rvalid1;
  logic [7:0]   maddr4, maddr1;
  logic [127:0] mq4, mq1, rdata4, rdata1;
  logic         busy4, busy1;

  typedef struct packed {
    logic [2:0]   v;
    logic [127:0] d;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk1  = 1'b0;

  function automatic logic [127:0] memf(input logic [7:0] a);
    return {8{a, a ^ 8'h5A}};
  endfunction

  assign mq4 = memf(maddr4);
  assign mq1 = memf(maddr1);

  softmax_rd_arbiter #(.DWIDTH(128), .AWIDTH(8), .BURST(4)) dut4 (
    .clk(clk), .reset(reset), .init(init), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .gnt(gnt4), .mem_addr(maddr4), .mem_q(mq4),
    .rdata(rdata4), .rvalid(rvalid4), .busy(busy4)
  );

  softmax_rd_arbiter #(.DWIDTH(128), .AWIDTH(8), .BURST(1)) dut1 (
    .clk(clk), .reset(reset), .init(init), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .gnt(gnt1), .mem_addr(maddr1), .mem_q(mq1),
    .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational grant, queue the read.
  task automatic step(input logic [2:0] r, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] a2, input logic rs, input logic it,
                      input logic [2:0] eg, input int eb, input string nm);
    logic [7:0] ea;
    @(negedge clk);
    req = r; addr0 = a0; addr1 = a1; addr2 = a2; reset = rs; init = it;
    #1;
    ea = eg[0] ? a0 : eg[1] ? a1 : eg[2] ? a2 : 8'd0;
    if (!chk1) begin
      check({nm, " gnt"}, gnt4, eg);
      check({nm, " mem_addr"}, maddr4, ea);
      if (eb >= 0) check({nm, " busy"}, busy4, eb[0]);
      if (eg != 3'b000 && !rs && !it) q4.push_back('{v: eg, d: memf(ea)});
    end else begin
      check({nm, " gnt"}, gnt1, eg);
      check({nm, " mem_addr"}, maddr1, ea);
      if (eb >= 0) check({nm, " busy"}, busy1, eb[0]);
      if (eg != 3'b000 && !rs && !it) q1.push_back('{v: eg, d: memf(ea)});
    end
  endtask

  always @(posedge clk) begin : mon4
    exp_t e;
    #1;
    if (!chk1 && rvalid4 !== 3'b000) begin
      if (q4.size() == 0) check("rvalid4 unexpected", rvalid4, 0);
      else begin
        e = q4.pop_front();
        check("rvalid4", rvalid4, e.v);
        check("rdata4", rdata4, e.d);
      end
    end
  end

  always @(posedge clk) begin : mon1
    exp_t e;
    #1;
    if (chk1 && rvalid1 !== 3'b000) begin
      if (q1.size() == 0) check("rvalid1 unexpected", rvalid1, 0);
      else begin
        e = q1.pop_front();
        check("rvalid1", rvalid1, e.v);
        check("rdata1", rdata1, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; init = 1'b0; req = 3'b000; addr0 = 8'd0; addr1 = 8'd0; addr2 = 8'd0;
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 3'b000, -1, "rst");
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 3'b000, -1, "rst");
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'b000, 0, "post rst");
    check("reset rvalid", rvalid4, 0);
    check("reset rdata", rdata4, 0);

    // Single requester: no gaps across burst boundaries.
    for (int i = 0; i < 8; i++)
      step(3'b001, 8'(i), 8'd0, 8'd0, 1'b0, 1'b0, 3'b001, (i == 0 || i == 4) ? 0 : 1, "single");
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'b000, 0, "single idle");

    // Two-way contention: 0,0,0,0,1,1,1,1,0,0.
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 3'b000, -1, "rst");
    for (int i = 0; i < 10; i++)
      step(3'b011, 8'(8'h10 + i), 8'(8'h20 + i), 8'd0, 1'b0, 1'b0,
           (i < 4 || i >= 8) ? 3'b001 : 3'b010,
           (i == 0 || i == 4 || i == 8) ? 0 : 1, "two-way");
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'b000, 1, "two-way idle");

    // Owner drops early.
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 3'b000, -1, "rst");
    step(3'b101, 8'h30, 8'd0, 8'h50, 1'b0, 1'b0, 3'b001, 0, "drop b0");
    step(3'b101, 8'h31, 8'd0, 8'h50, 1'b0, 1'b0, 3'b001, 1, "drop b1");
    step(3'b100, 8'h31, 8'd0, 8'h50, 1'b0, 1'b0, 3'b100, 1, "drop gnt2");
    step(3'b011, 8'h32, 8'h40, 8'd0, 1'b0, 1'b0, 3'b001, 1, "drop ptr0");
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'b000, 1, "drop idle");

    // Reset mid-burst to requester 1.
    step(3'b010, 8'd0, 8'h60, 8'd0, 1'b0, 1'b0, 3'b010, 0, "mid b0");
    step(3'b010, 8'd0, 8'h61, 8'd0, 1'b0, 1'b0, 3'b010, 1, "mid b1");
    step(3'b010, 8'd0, 8'h62, 8'd0, 1'b1, 1'b0, 3'b010, 1, "mid rst");
    step(3'b110, 8'd0, 8'h63, 8'h70, 1'b0, 1'b0, 3'b010, 0, "mid post");
    check("mid rvalid", rvalid4, 0);
    check("mid rdata", rdata4, 0);
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'b000, 1, "mid idle");

    // Idle with ptr=2, init pulse, then 3'b101 must go to 0.
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 3'b000, 0, "init");
    step(3'b101, 8'h90, 8'd0, 8'hA0, 1'b0, 1'b0, 3'b001, 0, "init gnt");
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'b000, 1, "init idle");

    // BURST=1: pure round-robin on the second instance.
    chk1 = 1'b1;
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 3'b000, -1, "rst");
    for (int i = 0; i < 6; i++)
      step(3'b111, 8'(i), 8'(8'h10 + i), 8'(8'h20 + i), 1'b0, 1'b0,
           3'(1 << (i % 3)), 0, "rr3");
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'b000, 0, "rr3 idle");
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'b000, 0, "rr3 idle");
    chk1 = 1'b0;
    step(3'b000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'b000, 0, "final idle");

    check("q4 drained", 128'(q4.size()), 0);
    check("q1 drained", 128'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
